// File: rtl/sap_ram_loader.sv
// sap_ram_loader: streams a 16-byte program into a pair of f189 16x4 RAMs and
// read-verifies every word through the chips' inverted outputs.
module sap_ram_loader #(
    parameter int WE_CYCLES = 2,
    parameter int WORDS     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       busy,
    output logic       done,
    output logic       verify_err,
    output logic [3:0] err_addr,
    output logic [3:0] ram_a,
    output logic [7:0] ram_d,
    output logic       ram_cs_n,
    output logic       ram_we_n,
    input  logic [7:0] ram_q_n
);
    localparam int CW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [CW-1:0] WE_LAST = CW'(WE_CYCLES - 1);
    localparam logic [3:0] A_LAST = 4'(WORDS - 1);

    typedef enum logic [2:0] {IDLE, WAIT, SETUP, WRITE, HOLD, VERIFY, DONE} state_t;

    state_t state;
    logic [CW-1:0] wcnt;

    // The async reset parks cs_n/we_n high at once, aborting any write in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wcnt       <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            verify_err <= 1'b0;
            err_addr   <= '0;
            ram_a      <= '0;
            ram_d      <= '0;
            ram_cs_n   <= 1'b1;
            ram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state      <= WAIT;
                    ram_a      <= '0;
                    busy       <= 1'b1;
                    done       <= 1'b0;
                    verify_err <= 1'b0;
                    err_addr   <= '0;
                    in_ready   <= 1'b1;
                end
                WAIT: if (in_valid) begin
                    ram_d    <= in_data;
                    in_ready <= 1'b0;
                    ram_cs_n <= 1'b0;
                    state    <= SETUP;
                end
                SETUP: begin
                    ram_we_n <= 1'b0;
                    wcnt     <= '0;
                    state    <= WRITE;
                end
                WRITE: if (wcnt == WE_LAST) begin
                    ram_we_n <= 1'b1;
                    state    <= HOLD;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                HOLD: state <= VERIFY;
                VERIFY: begin
                    // Only the first bad address is kept.
                    if ((~ram_q_n != ram_d) && !verify_err) begin
                        verify_err <= 1'b1;
                        err_addr   <= ram_a;
                    end
                    ram_cs_n <= 1'b1;
                    if (ram_a == A_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        ram_a    <= ram_a + 1'b1;
                        in_ready <= 1'b1;
                        state    <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sap_ram_loader.sv
// tb_sap_ram_loader: directed vectors plus load/stall/fault/abort sequences
// against an f189 pair model with a write-protocol monitor.
module tb_sap_ram_loader;
    localparam int WE = 2;

    logic       clk, rst_n, start, in_valid;
    logic [7:0] in_data;
    logic       in_ready, busy, done, verify_err;
    logic [3:0] err_addr, ram_a;
    logic [7:0] ram_d, ram_q_n;
    logic       ram_cs_n, ram_we_n;
    logic       clk_on, fault;

    logic [7:0] mem [16];
    int         wcount [16];
    int         pass_n, total_n;
    int         len;
    logic [3:0] wa;
    logic [7:0] wd;

    sap_ram_loader #(.WE_CYCLES(WE), .WORDS(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .busy(busy), .done(done),
        .verify_err(verify_err), .err_addr(err_addr), .ram_a(ram_a),
        .ram_d(ram_d), .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n),
        .ram_q_n(ram_q_n)
    );

    initial begin
        clk = 1'b0;
        wait (clk_on);
        forever #5 clk = ~clk;
    end

    // f189 pair: inverted read outputs, optional q_n bit 5 stuck low from address 3
    assign ram_q_n = (!ram_cs_n && ram_we_n)
        ? (~mem[ram_a] & ((fault && ram_a >= 4'd3) ? 8'hDF : 8'hFF)) : 8'hFF;

    always @(negedge clk)
        if (!ram_cs_n && !ram_we_n) mem[ram_a] <= ram_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst_n) len = 0;
        else if (!ram_we_n) begin
            if (len == 0) begin wa = ram_a; wd = ram_d; end
            chk("we_cs_a_d_stable", {ram_cs_n, ram_a, ram_d}, {1'b0, wa, wd});
            len++;
        end else if (len != 0) begin
            chk("we_window_len", len, WE);
            wcount[ram_a]++;
            len = 0;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic clear_wcount();
        for (int i = 0; i < 16; i++) wcount[i] = 0;
    endtask

    task automatic chk_mem(input logic [7:0] base, input int from);
        for (int i = from; i < 16; i++) chk($sformatf("mem[%0d]", i), mem[i], base + 8'(i));
    endtask

    task automatic chk_once(input int from);
        int bad = 0;
        for (int i = from; i < 16; i++) if (wcount[i] != 1) bad++;
        chk("each_word_written_once", bad, 0);
    endtask

    task automatic stream(input int first, input logic [7:0] base, input int stall_at,
                          input int abort_at, output int cycles, output int stall_bad,
                          output logic aborted);
        int idx = first, st = 0;
        logic hs;
        cycles = 0; stall_bad = 0; aborted = 1'b0;
        while (!done && cycles < 2000) begin
            if (abort_at >= 0 && idx == abort_at + 1 && !ram_we_n) begin
                aborted = 1'b1;
                break;
            end
            if (idx == stall_at && st < 10) begin
                in_valid = 1'b0;
                if (in_ready) begin
                    st++;
                    if (ram_cs_n !== 1'b1) stall_bad++;
                end
            end else begin
                in_valid = idx < 16;
                in_data  = base + 8'(idx);
            end
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            cycles++;
            if (hs) idx++;
        end
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic [16:0] exp;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [10];
        int cyc, sb;
        logic ab;
        // exp = {in_ready, busy, done, cs_n, we_n, a[3:0], d[7:0]}
        vt[0] = '{1'b0, 1'b1, 8'h77, {5'b00011, 4'd0, 8'h00}};
        vt[1] = '{1'b1, 1'b0, 8'h00, {5'b11011, 4'd0, 8'h00}};
        vt[2] = '{1'b0, 1'b0, 8'h00, {5'b11011, 4'd0, 8'h00}};
        vt[3] = '{1'b0, 1'b1, 8'hA5, {5'b01001, 4'd0, 8'hA5}};
        vt[4] = '{1'b0, 1'b0, 8'h00, {5'b01000, 4'd0, 8'hA5}};
        vt[5] = '{1'b0, 1'b0, 8'h00, {5'b01000, 4'd0, 8'hA5}};
        vt[6] = '{1'b0, 1'b0, 8'h00, {5'b01001, 4'd0, 8'hA5}};
        vt[7] = '{1'b0, 1'b0, 8'h00, {5'b01001, 4'd0, 8'hA5}};
        vt[8] = '{1'b0, 1'b0, 8'h00, {5'b11011, 4'd1, 8'hA5}};
        vt[9] = '{1'b1, 1'b0, 8'h00, {5'b11011, 4'd1, 8'hA5}};

        pass_n = 0; total_n = 0; len = 0; wa = '0; wd = '0;
        clk_on = 1'b0; fault = 1'b0;
        start = 1'b0; in_valid = 1'b0; in_data = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        clear_wcount();

        // reset with no clock
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        chk("rst_outputs", {ram_cs_n, ram_we_n, in_ready, busy, done, verify_err},
            6'b110000);
        chk("rst_a_d_err", {ram_a, ram_d, err_addr}, 16'h0);
        #3 rst_n = 1'b1;
        clk_on = 1'b1;
        @(posedge clk); #1;

        // directed cycle vectors: idle valid, start, stall, first word, ignored start
        for (int i = 0; i < 10; i++) begin
            start = vt[i].start; in_valid = vt[i].valid; in_data = vt[i].data;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i),
                {in_ready, busy, done, ram_cs_n, ram_we_n, ram_a, ram_d}, vt[i].exp);
        end
        start = 1'b0; in_valid = 1'b0;
        stream(1, 8'h00, -1, -1, cyc, sb, ab);
        chk("vec_load_done", {done, busy, verify_err}, 3'b100);
        chk("mem[0]", mem[0], 8'hA5);
        chk_mem(8'h00, 1);

        // full back-to-back load
        clear_wcount();
        pulse_start();
        stream(0, 8'h00, -1, -1, cyc, sb, ab);
        chk("full_cycles", cyc, 96);
        chk("full_flags", {done, busy, verify_err, ram_cs_n, ram_we_n}, 5'b10011);
        chk_mem(8'h00, 0);
        chk_once(0);

        // stall at word 7
        clear_wcount();
        pulse_start();
        stream(0, 8'hC0, 7, -1, cyc, sb, ab);
        chk("stall_cycles", cyc, 106);
        chk("stall_cs_high", sb, 0);
        chk("stall_word7_once", wcount[7], 1);
        chk("stall_flags", {done, verify_err}, 2'b10);
        chk_mem(8'hC0, 0);

        // stuck-at fault from address 3 on
        fault = 1'b1;
        pulse_start();
        stream(0, 8'h00, -1, -1, cyc, sb, ab);
        chk("fault_flags", {done, verify_err}, 2'b11);
        chk("fault_err_addr", err_addr, 4'd3);
        fault = 1'b0;

        // abort during word 9 write, then reload
        pulse_start();
        chk("start_clears", {done, verify_err, err_addr}, 6'b0);
        stream(0, 8'h00, -1, 9, cyc, sb, ab);
        chk("abort_reached", ab, 1'b1);
        chk("abort_in_write", {ram_we_n, ram_cs_n, ram_a}, {2'b00, 4'd9});
        #2 rst_n = 1'b0;
        #1;
        chk("abort_async", {ram_we_n, ram_cs_n, busy, in_ready}, 4'b1100);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_wcount();
        pulse_start();
        stream(0, 8'h50, -1, -1, cyc, sb, ab);
        chk("reload_flags", {done, busy, verify_err}, 3'b100);
        chk_mem(8'h50, 0);
        chk_once(0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
